// File: rtl/parking_gate_controller_if.sv
// -----------------------------------------------------------------------------
// parking_gate_controller_if
//
// Purpose: groups every signal between the gate hardware / parking_logic and
// parking_gate_controller into one bundle.
//
// Signals:
//   entry_req, entry_is_uni, entry_beam         entry request, badge class, beam
//   exit_req,  exit_is_uni,  exit_beam          exit request, badge class, beam
//   uni_is_vacated_space, is_vacated_space      space flags from parking_logic
//   entry_barrier_open, exit_barrier_open       barrier drives
//   entry_denied                                one-cycle "no space" pulse
//   car_entered, is_uni_car_entered             entry event pulse + class
//   car_exited,  is_uni_car_exited              exit event pulse + class
//   entry_busy, exit_busy                       gate FSM not idle
//   denied_count, timeout_count                 statistics, present only when
//                                               PARKING_GATE_STATS_EN is defined
//
// Modports:
//   master  the environment side (gate hardware, parking_logic, testbench)
//   slave   the controller
// -----------------------------------------------------------------------------
interface parking_gate_controller_if;

  logic entry_req;
  logic entry_is_uni;
  logic entry_beam;
  logic exit_req;
  logic exit_is_uni;
  logic exit_beam;
  logic uni_is_vacated_space;
  logic is_vacated_space;

  logic entry_barrier_open;
  logic exit_barrier_open;
  logic entry_denied;
  logic car_entered;
  logic is_uni_car_entered;
  logic car_exited;
  logic is_uni_car_exited;
  logic entry_busy;
  logic exit_busy;

`ifdef PARKING_GATE_STATS_EN
  logic [15:0] denied_count;
  logic [15:0] timeout_count;

  modport master (
    output entry_req, entry_is_uni, entry_beam,
    output exit_req, exit_is_uni, exit_beam,
    output uni_is_vacated_space, is_vacated_space,
    input  entry_barrier_open, exit_barrier_open, entry_denied,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  entry_busy, exit_busy,
    input  denied_count, timeout_count
  );

  modport slave (
    input  entry_req, entry_is_uni, entry_beam,
    input  exit_req, exit_is_uni, exit_beam,
    input  uni_is_vacated_space, is_vacated_space,
    output entry_barrier_open, exit_barrier_open, entry_denied,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output entry_busy, exit_busy,
    output denied_count, timeout_count
  );
`else
  modport master (
    output entry_req, entry_is_uni, entry_beam,
    output exit_req, exit_is_uni, exit_beam,
    output uni_is_vacated_space, is_vacated_space,
    input  entry_barrier_open, exit_barrier_open, entry_denied,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  entry_busy, exit_busy
  );

  modport slave (
    input  entry_req, entry_is_uni, entry_beam,
    input  exit_req, exit_is_uni, exit_beam,
    input  uni_is_vacated_space, is_vacated_space,
    output entry_barrier_open, exit_barrier_open, entry_denied,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output entry_busy, exit_busy
  );
`endif

endinterface

// File: rtl/parking_gate_controller.sv
// -----------------------------------------------------------------------------
// parking_gate_controller
//
// Purpose: runs the entry and exit barriers and turns each physical car
// passage into a single-cycle car_entered / car_exited pulse (with class
// flag) for parking_logic. Entry is granted only when parking_logic reports
// space of the requested class.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset; both gates return to IDLE and
//            every output drops to 0
//   bus      parking_gate_controller_if.slave (see the interface header)
//
// Parameters:
//   TIMEOUT_CYC  cycles an open barrier waits for the beam before closing
//   CLOSE_HOLD   cycles a gate stays busy after closing (must be >= 1)
//   CW           width of the timeout/hold counters
//
// Optional feature (macro PARKING_GATE_STATS_EN): adds saturating
// denied_count and timeout_count outputs.
//
// Timing: every output is a flop computed from the next state, so barrier,
// busy and event outputs line up with the state the gate is in.
// -----------------------------------------------------------------------------
module parking_gate_controller #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int CLOSE_HOLD  = 4,
  parameter int CW          = 16
) (
  input logic                        clk,
  input logic                        reset_n,
  parking_gate_controller_if.slave   bus
);

  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(CLOSE_HOLD - 1);

  typedef enum logic [2:0] {
    E_IDLE, E_OPEN, E_PASS, E_COMMIT, E_CLOSE
  } entry_state_t;

  typedef enum logic [2:0] {
    X_IDLE, X_OPEN, X_PASS, X_COMMIT, X_CLOSE
  } exit_state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  entry_state_t    e_state_q, e_state_d;
  exit_state_t     x_state_q, x_state_d;
  logic [CW-1:0]   e_cnt_q, e_cnt_d;
  logic [CW-1:0]   x_cnt_q, x_cnt_d;
  logic            e_uni_q, e_uni_d;     // class latched at entry request
  logic            x_uni_q, x_uni_d;     // class latched at exit request

  logic entry_barrier_open_q, entry_barrier_open_d;
  logic exit_barrier_open_q,  exit_barrier_open_d;
  logic entry_denied_q,       entry_denied_d;
  logic car_entered_q,        car_entered_d;
  logic is_uni_car_entered_q, is_uni_car_entered_d;
  logic car_exited_q,         car_exited_d;
  logic is_uni_car_exited_q,  is_uni_car_exited_d;
  logic entry_busy_q,         entry_busy_d;
  logic exit_busy_q,          exit_busy_d;

  logic e_space;

  // Space flag of the class presented with the request.
  assign e_space = bus.entry_is_uni ? bus.uni_is_vacated_space
                                    : bus.is_vacated_space;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the combinational blocks below use blocking (=).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_state_q            <= E_IDLE;
      x_state_q            <= X_IDLE;
      e_cnt_q              <= '0;
      x_cnt_q              <= '0;
      e_uni_q              <= 1'b0;
      x_uni_q              <= 1'b0;
      entry_barrier_open_q <= 1'b0;
      exit_barrier_open_q  <= 1'b0;
      entry_denied_q       <= 1'b0;
      car_entered_q        <= 1'b0;
      is_uni_car_entered_q <= 1'b0;
      car_exited_q         <= 1'b0;
      is_uni_car_exited_q  <= 1'b0;
      entry_busy_q         <= 1'b0;
      exit_busy_q          <= 1'b0;
    end else begin
      e_state_q            <= e_state_d;
      x_state_q            <= x_state_d;
      e_cnt_q              <= e_cnt_d;
      x_cnt_q              <= x_cnt_d;
      e_uni_q              <= e_uni_d;
      x_uni_q              <= x_uni_d;
      entry_barrier_open_q <= entry_barrier_open_d;
      exit_barrier_open_q  <= exit_barrier_open_d;
      entry_denied_q       <= entry_denied_d;
      car_entered_q        <= car_entered_d;
      is_uni_car_entered_q <= is_uni_car_entered_d;
      car_exited_q         <= car_exited_d;
      is_uni_car_exited_q  <= is_uni_car_exited_d;
      entry_busy_q         <= entry_busy_d;
      exit_busy_q          <= exit_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    e_state_d      = e_state_q;
    e_cnt_d        = '0;
    e_uni_d        = e_uni_q;
    entry_denied_d = 1'b0;
    unique case (e_state_q)
      E_IDLE: begin
        if (bus.entry_req) begin
          e_uni_d = bus.entry_is_uni;
          if (e_space) e_state_d      = E_OPEN;
          else         entry_denied_d = 1'b1;
        end
      end
      E_OPEN: begin
        if (bus.entry_beam)              e_state_d = E_PASS;
        else if (e_cnt_q == TIMEOUT_LAST) e_state_d = E_CLOSE;
        else                             e_cnt_d   = e_cnt_q + 1'b1;
      end
      E_PASS: begin
        // No timeout here: a car may stop under the barrier.
        if (!bus.entry_beam) e_state_d = E_COMMIT;
      end
      E_COMMIT: begin
        // Leave only once the pulse has actually been issued; a collision
        // with the exit gate keeps us here one extra cycle.
        if (car_entered_q) e_state_d = E_CLOSE;
      end
      E_CLOSE: begin
        if (e_cnt_q == HOLD_LAST) e_state_d = E_IDLE;
        else                      e_cnt_d   = e_cnt_q + 1'b1;
      end
      default: e_state_d = E_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Exit FSM next state (no space check)
  // ---------------------------------------------------------------------------
  always_comb begin
    x_state_d = x_state_q;
    x_cnt_d   = '0;
    x_uni_d   = x_uni_q;
    unique case (x_state_q)
      X_IDLE: begin
        if (bus.exit_req) begin
          x_uni_d   = bus.exit_is_uni;
          x_state_d = X_OPEN;
        end
      end
      X_OPEN: begin
        if (bus.exit_beam)               x_state_d = X_PASS;
        else if (x_cnt_q == TIMEOUT_LAST) x_state_d = X_CLOSE;
        else                             x_cnt_d   = x_cnt_q + 1'b1;
      end
      X_PASS: begin
        if (!bus.exit_beam) x_state_d = X_COMMIT;
      end
      X_COMMIT: begin
        // Exit always wins arbitration, so it fires on its first cycle here.
        x_state_d = X_CLOSE;
      end
      X_CLOSE: begin
        if (x_cnt_q == HOLD_LAST) x_state_d = X_IDLE;
        else                      x_cnt_d   = x_cnt_q + 1'b1;
      end
      default: x_state_d = X_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, derived from the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_barrier_open_d = (e_state_d == E_OPEN) || (e_state_d == E_PASS);
    exit_barrier_open_d  = (x_state_d == X_OPEN) || (x_state_d == X_PASS);
    entry_busy_d         = (e_state_d != E_IDLE);
    exit_busy_d          = (x_state_d != X_IDLE);

    // Exit enters COMMIT for exactly one cycle and always pulses then.
    car_exited_d = (x_state_d == X_COMMIT);
    // Entry pulses in any COMMIT cycle the exit gate is not using.
    car_entered_d = (e_state_d == E_COMMIT) && (x_state_d != X_COMMIT);

    // Class flags hold their value until the next event of that gate.
    is_uni_car_entered_d = car_entered_d ? e_uni_d : is_uni_car_entered_q;
    is_uni_car_exited_d  = car_exited_d  ? x_uni_d : is_uni_car_exited_q;
  end

  assign bus.entry_barrier_open = entry_barrier_open_q;
  assign bus.exit_barrier_open  = exit_barrier_open_q;
  assign bus.entry_denied       = entry_denied_q;
  assign bus.car_entered        = car_entered_q;
  assign bus.is_uni_car_entered = is_uni_car_entered_q;
  assign bus.car_exited         = car_exited_q;
  assign bus.is_uni_car_exited  = is_uni_car_exited_q;
  assign bus.entry_busy         = entry_busy_q;
  assign bus.exit_busy          = exit_busy_q;

`ifdef PARKING_GATE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: saturating denied / timeout counters
  // ---------------------------------------------------------------------------
  logic [15:0] denied_count_q, denied_count_d;
  logic [15:0] timeout_count_q, timeout_count_d;
  logic        e_timeout, x_timeout;
  logic [16:0] timeout_sum;

  // A timeout is the only OPEN -> CLOSE transition.
  assign e_timeout = (e_state_q == E_OPEN) && (e_state_d == E_CLOSE);
  assign x_timeout = (x_state_q == X_OPEN) && (x_state_d == X_CLOSE);

  always_comb begin
    denied_count_d = denied_count_q;
    if (entry_denied_d && (denied_count_q != 16'hFFFF))
      denied_count_d = denied_count_q + 16'd1;

    // Both gates may time out in the same cycle, so add up to two at once.
    timeout_sum     = {1'b0, timeout_count_q} + {16'd0, e_timeout}
                                              + {16'd0, x_timeout};
    timeout_count_d = timeout_sum[16] ? 16'hFFFF : timeout_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      denied_count_q  <= '0;
      timeout_count_q <= '0;
    end else begin
      denied_count_q  <= denied_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign bus.denied_count  = denied_count_q;
  assign bus.timeout_count = timeout_count_q;
`endif

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Event producer for parking_logic: runs the entry and exit barriers and turns physical car passages into the single-cycle car_entered / car_exited pulses (with uni flags) that parking_logic counts.
- Entry is admitted only when parking_logic reports space of the matching class.
- Sits between the gate hardware (request buttons, badge reader, beam sensors) and parking_logic.

Parameters:
- TIMEOUT_CYC, 1000: cycles a barrier stays open waiting for the beam to break before closing with no event.
- CLOSE_HOLD, 4: cycles a gate stays busy after closing before it accepts a new request.
- CW, 16: width of the internal timeout/hold counters; must hold max(TIMEOUT_CYC, CLOSE_HOLD).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- entry_req  input  1  car waiting at entry; level, sampled only in E_IDLE.
- entry_is_uni  input  1  badge class at entry, sampled with entry_req.
- entry_beam  input  1  entry beam broken (1 = car in gate).
- exit_req  input  1  car waiting at exit; level, sampled only in X_IDLE.
- exit_is_uni  input  1  badge class at exit, sampled with exit_req.
- exit_beam  input  1  exit beam broken.
- uni_is_vacated_space  input  1  from parking_logic: uni space available.
- is_vacated_space  input  1  from parking_logic: non-uni space available.
- entry_barrier_open  output  1  entry barrier drive.
- exit_barrier_open  output  1  exit barrier drive.
- entry_denied  output  1  one-cycle pulse: request refused, no space.
- car_entered  output  1  one-cycle event pulse to parking_logic.
- is_uni_car_entered  output  1  class of the last entry; valid with car_entered, held until the next entry commit.
- car_exited  output  1  one-cycle event pulse to parking_logic.
- is_uni_car_exited  output  1  class of the last exit; held like is_uni_car_entered.
- entry_busy  output  1  entry FSM not in E_IDLE.
- exit_busy  output  1  exit FSM not in X_IDLE.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-passage): both FSMs go to IDLE, every output is 0, counters are 0. Any pending event is lost.

Entry FSM:
- E_IDLE: on entry_req=1, latch entry_is_uni.
  - Granted if the class's space flag is 1 (uni uses uni_is_vacated_space, non-uni uses is_vacated_space): go to E_OPEN; entry_barrier_open=1 from the next cycle.
  - Otherwise: entry_denied pulses one cycle and the FSM stays in E_IDLE. A held entry_req re-requests every cycle, so entry_denied can repeat.
- E_OPEN: counter counts cycles.
  - entry_beam=1: go to E_PASS.
  - Counter reaches TIMEOUT_CYC-1 with no beam: go to E_CLOSE; no event.
- E_PASS: wait for entry_beam=0 (no timeout; car may stop in the gate), then go to E_COMMIT.
- E_COMMIT: barrier_open=0; car_entered=1 for exactly one cycle; is_uni_car_entered=latched class. Then go to E_CLOSE.
- E_CLOSE: busy for CLOSE_HOLD cycles; requests ignored; then E_IDLE.
- The space flag is checked only at request time. A later drop of the flag does not abort the open/pass sequence; parking_logic saturates.

Exit FSM:
- Same states (X_*) with no space check: X_IDLE goes to X_OPEN on exit_req.
- The timeout and CLOSE_HOLD rules are identical.

Arbitration:
- car_entered and car_exited are never high in the same cycle.
- If both FSMs are in COMMIT together, exit fires first and entry stays in E_COMMIT one extra cycle, then fires.
- A beam that toggles back to 1 in E_COMMIT/E_CLOSE is ignored.

Optional Feature:
- Macro: PARKING_GATE_STATS_EN.
- Defined: adds outputs denied_count[15:0] and timeout_count[15:0].
  - denied_count: saturating count of entry_denied pulses.
  - timeout_count: saturating count of open timeouts from either gate.
  - Both reset to 0 and stick at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Uni pass: reset_n low 2 cycles then high; entry_req=1, entry_is_uni=1, uni_is_vacated_space=1; entry_beam 1 for 5 cycles then 0 -> barrier opens 1 cycle after request; exactly one car_entered pulse with is_uni_car_entered=1; entry_busy clears CLOSE_HOLD+1 cycles after the pulse.
- Deny: is_vacated_space=0, non-uni entry_req for 1 cycle -> one entry_denied pulse, barrier stays 0, no car_entered.
- Timeout: TIMEOUT_CYC=20, exit_req with no beam -> exit_barrier_open high 20 cycles then 0; no car_exited; timeout_count=1 when PARKING_GATE_STATS_EN is defined.
- Collision: align both FSMs into COMMIT in the same cycle -> car_exited at cycle T, car_entered at T+1, never overlapping.
- Reset mid-passage: assert reset_n in E_PASS -> all outputs 0 immediately; no car_entered after release.
- Loop: 500 uni entries then 200 non-uni entries driven into parking_logic -> exactly 700 car_entered pulses; parked_car matches parking_logic's own count.
